dsc_s2b_rx: RTL and testbench

//  Stochastic-to-binary receiver at the output end of the deterministic SC datapath.

---
 rtl/dsc_s2b_rx_if.sv | 26 ++
 rtl/dsc_s2b_rx.sv | 95 +++++++++
 tb/tb_dsc_s2b_rx.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/dsc_s2b_rx_if.sv
// Handshake/stream bundle between a DSC bitstream sender, the s2b receiver and the result consumer.
interface dsc_s2b_rx_if #(parameter int SNG_WIDTH = 4) ();
  localparam int W = 2 * SNG_WIDTH;

  logic         start;
  logic         sn_in;
  logic         sn_valid;
  logic         es_stop;
  logic [W-1:0] z;
  logic [W:0]   len_out;
  logic         early;
  logic         sat;
  logic         busy;
  logic         z_valid;
  logic         z_ready;

  modport master (
    output start, sn_in, sn_valid, es_stop, z_ready,
    input  z, len_out, early, sat, busy, z_valid
  );

  modport slave (
    input  start, sn_in, sn_valid, es_stop, z_ready,
    output z, len_out, early, sat, busy, z_valid
  );
endinterface

// File: rtl/dsc_s2b_rx.sv
// Stochastic-to-binary receiver: counts ones over a bounded window (length or early shutoff)
// and presents the saturated count, length and status over a valid/ready handshake.
module dsc_s2b_rx #(
  parameter int SNG_WIDTH  = 4,
  parameter int STREAM_LEN = 2 ** (2 * SNG_WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  dsc_s2b_rx_if.slave   rx
);
  localparam int W = 2 * SNG_WIDTH;
  localparam logic [W:0] LAST = (W+1)'(STREAM_LEN - 1);
  localparam logic [W:0] MAXV = (W+1)'((1 << W) - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [W:0]   ones_q, ones_d, len_q, len_d;
  logic [W:0]   ones_nx, len_nx;
  logic [W-1:0] z_q, z_d;
  logic [W:0]   len_out_q, len_out_d;
  logic         early_q, early_d, sat_q, sat_d;
  logic         busy_q, z_valid_q;

  // The bit on the ending cycle is folded in before the result is captured.
  assign ones_nx = ones_q + {{W{1'b0}}, rx.sn_valid & rx.sn_in};
  assign len_nx  = len_q  + {{W{1'b0}}, rx.sn_valid};

  always_comb begin
    state_d   = state_q;
    ones_d    = ones_q;
    len_d     = len_q;
    z_d       = z_q;
    len_out_d = len_out_q;
    early_d   = early_q;
    sat_d     = sat_q;
    case (state_q)
      IDLE: begin
        if (rx.start) begin
          state_d = ACCUM;
          ones_d  = '0;
          len_d   = '0;
        end
      end
      ACCUM: begin
        ones_d = ones_nx;
        len_d  = len_nx;
        if ((rx.sn_valid && (len_q == LAST)) || rx.es_stop) begin
          state_d   = DONE;
          sat_d     = (ones_nx > MAXV);
          z_d       = sat_d ? {W{1'b1}} : ones_nx[W-1:0];
          len_out_d = len_nx;
          early_d   = rx.es_stop;
        end
      end
      DONE: begin
        if (rx.z_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ones_q    <= '0;
      len_q     <= '0;
      z_q       <= '0;
      len_out_q <= '0;
      early_q   <= 1'b0;
      sat_q     <= 1'b0;
      busy_q    <= 1'b0;
      z_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ones_q    <= ones_d;
      len_q     <= len_d;
      z_q       <= z_d;
      len_out_q <= len_out_d;
      early_q   <= early_d;
      sat_q     <= sat_d;
      busy_q    <= (state_d == ACCUM);
      z_valid_q <= (state_d == DONE);
    end
  end

  assign rx.z       = z_q;
  assign rx.len_out = len_out_q;
  assign rx.early   = early_q;
  assign rx.sat     = sat_q;
  assign rx.busy    = busy_q;
  assign rx.z_valid = z_valid_q;
endmodule

// File: tb/tb_dsc_s2b_rx.sv
// Randomized directed bench for dsc_s2b_rx against a window-level reference model.
module tb_dsc_s2b_rx;
  localparam int SW = 4;
  localparam int SL = 256;
  localparam int MX = 255;

  typedef struct {
    bit v;
    bit b;
    bit e;
  } stp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  stp_t seq[$];
  int   exp_z, exp_len, exp_early, exp_sat;

  dsc_s2b_rx_if #(.SNG_WIDTH(SW)) dif ();

  dsc_s2b_rx #(.SNG_WIDTH(SW), .STREAM_LEN(SL)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (dif.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    dif.start    = 1'b0;
    dif.sn_valid = 1'b0;
    dif.sn_in    = 1'b0;
    dif.es_stop  = 1'b0;
  endtask

  // nv valid bits holding exactly nones ones, random order, optional gaps; es on last valid bit
  task automatic build(input int nv, input int nones, input int gap_pct, input bit gap_one,
                       input bit es_last);
    bit bits[];
    bits = new[nv];
    for (int i = 0; i < nv; i++) bits[i] = (i < nones);
    for (int i = nv - 1; i > 0; i--) begin
      int j;
      bit t;
      j = $urandom_range(i, 0);
      t = bits[i]; bits[i] = bits[j]; bits[j] = t;
    end
    seq.delete();
    for (int i = 0; i < nv; i++) begin
      while ($urandom_range(99, 0) < gap_pct)
        seq.push_back('{v: 1'b0, b: gap_one ? 1'b1 : 1'($urandom_range(1, 0)), e: 1'b0});
      seq.push_back('{v: 1'b1, b: bits[i], e: (es_last && i == nv - 1)});
    end
  endtask

  // Reference: walk the stream, stop at the first step that fills the window or carries es.
  task automatic run_seq(input string tag);
    int ones, len, endi, prem;
    ones = 0; len = 0; endi = -1; prem = 0;
    foreach (seq[i]) begin
      if (endi < 0) begin
        if (seq[i].v) begin
          len++;
          ones += seq[i].b;
        end
        if ((seq[i].v && len == SL) || seq[i].e) endi = i;
      end
    end
    if (endi < 0) begin
      chk({tag, ":model_end"}, 32'(endi), 32'(0));
      return;
    end
    exp_z     = (ones > MX) ? MX : ones;
    exp_sat   = (ones > MX) ? 1 : 0;
    exp_len   = len;
    exp_early = seq[endi].e;

    dif.start = 1'b1;
    tick();
    dif.start = 1'b0;
    for (int i = 0; i <= endi; i++) begin
      dif.sn_valid = seq[i].v;
      dif.sn_in    = seq[i].b;
      dif.es_stop  = seq[i].e;
      if (dif.z_valid !== 1'b0 || dif.busy !== 1'b1) prem++;
      tick();
    end
    idle_inputs();
    chk({tag, ":premature"}, 32'(prem), 32'(0));
    chk({tag, ":z_valid"},   32'(dif.z_valid), 32'(1));
    chk({tag, ":busy"},      32'(dif.busy), 32'(0));
    chk({tag, ":z"},         32'(dif.z), 32'(exp_z));
    chk({tag, ":len_out"},   32'(dif.len_out), 32'(exp_len));
    chk({tag, ":early"},     32'(dif.early), 32'(exp_early));
    chk({tag, ":sat"},       32'(dif.sat), 32'(exp_sat));
  endtask

  task automatic accept(input string tag);
    dif.z_ready = 1'b1;
    tick();
    dif.z_ready = 1'b0;
    chk({tag, ":acc_zv"},  32'(dif.z_valid), 32'(0));
    chk({tag, ":acc_z"},   32'(dif.z), 32'(exp_z));
    chk({tag, ":acc_len"}, 32'(dif.len_out), 32'(exp_len));
  endtask

  initial begin
    int held;
    idle_inputs();
    dif.z_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    chk("rst:z",       32'(dif.z), 32'(0));
    chk("rst:len",     32'(dif.len_out), 32'(0));
    chk("rst:early",   32'(dif.early), 32'(0));
    chk("rst:sat",     32'(dif.sat), 32'(0));
    chk("rst:busy",    32'(dif.busy), 32'(0));
    chk("rst:z_valid", 32'(dif.z_valid), 32'(0));
    rst = 1'b0;
    tick();

    build(256, 225, 0, 1'b0, 1'b0);
    run_seq("full225");
    accept("full225");

    build(256, 256, 0, 1'b0, 1'b0);
    run_seq("allones");
    accept("allones");

    build(40, 11, 0, 1'b0, 1'b0);
    seq.push_back('{v: 1'b1, b: 1'b1, e: 1'b1});
    run_seq("es41");

    // result pending while downstream stalls; a start pulse must not open a window
    held = 0;
    for (int i = 0; i < 5; i++) begin
      dif.start = (i == 2);
      tick();
      if (dif.z_valid !== 1'b1 || dif.z !== 8'(exp_z) || dif.busy !== 1'b0) held++;
    end
    dif.start = 1'b0;
    chk("stall:held", 32'(held), 32'(0));
    accept("stall");
    tick();
    chk("stall:no_queue_busy", 32'(dif.busy), 32'(0));
    chk("stall:no_queue_zv",   32'(dif.z_valid), 32'(0));

    // stream inputs in IDLE are ignored
    dif.sn_valid = 1'b1; dif.sn_in = 1'b1; dif.es_stop = 1'b1;
    tick(); tick(); tick();
    idle_inputs();
    chk("idle:busy", 32'(dif.busy), 32'(0));
    chk("idle:zv",   32'(dif.z_valid), 32'(0));
    chk("idle:z",    32'(dif.z), 32'(exp_z));

    // reset mid-window discards everything
    dif.start = 1'b1;
    tick();
    dif.start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      dif.sn_valid = 1'b1;
      dif.sn_in    = 1'($urandom_range(1, 0));
      tick();
    end
    idle_inputs();
    chk("midrst:busy_before", 32'(dif.busy), 32'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst:z",    32'(dif.z), 32'(0));
    chk("midrst:len",  32'(dif.len_out), 32'(0));
    chk("midrst:busy", 32'(dif.busy), 32'(0));
    chk("midrst:zv",   32'(dif.z_valid), 32'(0));
    build(10, 10, 0, 1'b0, 1'b1);
    run_seq("after_rst");
    accept("after_rst");

    build(256, $urandom_range(256, 0), 40, 1'b1, 1'b0);
    run_seq("gaps");
    accept("gaps");

    build(30, 10, 20, 1'b1, 1'b0);
    seq.push_back('{v: 1'b0, b: 1'b1, e: 1'b1});
    run_seq("es_on_gap");
    accept("es_on_gap");

    build(256, 200, 10, 1'b0, 1'b1);
    run_seq("es_and_len");
    accept("es_and_len");

    for (int k = 0; k < 4; k++) begin
      int nv;
      nv = $urandom_range(200, 1);
      build(nv, $urandom_range(nv, 0), 30, 1'b0, 1'b1);
      run_seq($sformatf("rnd%0d", k));
      accept($sformatf("rnd%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
